// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg -- register offsets, bit positions and channel view for multi_timer (rev 1.0)
`default_nettype none

package multi_timer_pkg;

  typedef enum logic [2:0] {
    REG_STATUS  = 3'd0,
    REG_CONTROL = 3'd1,
    REG_PERIODL = 3'd2,
    REG_PERIODH = 3'd3,
    REG_SNAPL   = 3'd4,
    REG_SNAPH   = 3'd5
  } reg_e;

  localparam int STAT_TO    = 0;
  localparam int STAT_RUN   = 1;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  // Everything the register read mux needs from one channel, widened to 32 bits.
  typedef struct packed {
    logic        run;
    logic        to_flag;
    logic        cont;
    logic        ito;
    logic [31:0] period;
    logic [31:0] snap;
  } ch_view_t;

endpackage

`default_nettype wire

// File: rtl/multi_timer_ch.sv
// multi_timer_ch -- one down-counting timer channel; snapshot register exists only with
// MULTI_TIMER_SNAPSHOT_EN defined (rev 1.0)
`default_nettype none

module multi_timer_ch
  import multi_timer_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter logic [31:0] RST_PERIOD = 32'h02FAF07F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en_i,
  input  logic [2:0]  wr_addr_i,
  input  logic [15:0] wr_data_i,
  output ch_view_t    view_o,
  output logic        timeout_pulse_o,
  output logic        irq_o
);

  localparam logic [CNT_W-1:0] RST_CNT = RST_PERIOD[CNT_W-1:0];

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] period_q;
  logic             run_q, to_q, cont_q, ito_q, reload_q, pulse_q;
  logic [31:0]      period_d;
  logic [31:0]      snap;
  logic             timeout, status_wr, ctrl_wr, periodl_wr, periodh_wr, period_wr;
  logic             unused_period_bits;

  assign timeout    = run_q && (count_q == '0);
  assign status_wr  = wr_en_i && (wr_addr_i == REG_STATUS);
  assign ctrl_wr    = wr_en_i && (wr_addr_i == REG_CONTROL);
  assign periodl_wr = wr_en_i && (wr_addr_i == REG_PERIODL);
  assign periodh_wr = wr_en_i && (wr_addr_i == REG_PERIODH);
  assign period_wr  = periodl_wr || periodh_wr;

  always_comb begin
    period_d = 32'(period_q);
    if (periodl_wr) period_d[15:0]  = wr_data_i;
    if (periodh_wr) period_d[31:16] = wr_data_i;
  end

  // Bits above CNT_W of a PERIODH write are simply dropped.
  assign unused_period_bits = ^period_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= RST_CNT;
      period_q <= RST_CNT;
      run_q    <= 1'b0;
      to_q     <= 1'b0;
      cont_q   <= 1'b0;
      ito_q    <= 1'b0;
      reload_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      pulse_q  <= timeout;
      reload_q <= period_wr;
      // A pending reload cannot coincide with counting: the period write cleared RUN.
      if (reload_q || timeout) count_q <= period_q;
      else if (run_q)          count_q <= count_q - 1'b1;

      if (timeout)        to_q <= 1'b1;
      else if (status_wr) to_q <= 1'b0;

      if (timeout) run_q <= cont_q;
      if (ctrl_wr) begin
        cont_q <= wr_data_i[CTRL_CONT];
        ito_q  <= wr_data_i[CTRL_ITO];
        if (wr_data_i[CTRL_STOP])       run_q <= 1'b0;
        else if (wr_data_i[CTRL_START]) run_q <= 1'b1;
      end
      if (period_wr) begin
        period_q <= period_d[CNT_W-1:0];
        run_q    <= 1'b0;
      end
    end
  end

`ifdef MULTI_TIMER_SNAPSHOT_EN
  logic [31:0] snap_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                 snap_q <= '0;
    else if (wr_en_i && wr_addr_i == REG_SNAPL)   snap_q <= 32'(count_q);
  end
  assign snap = snap_q;
`else
  assign snap = '0;
`endif

  assign view_o          = {run_q, to_q, cont_q, ito_q, 32'(period_q), snap};
  assign timeout_pulse_o = pulse_q;
  assign irq_o           = to_q && ito_q;

endmodule

`default_nettype wire

// File: rtl/multi_timer.sv
// multi_timer -- NUM_CH independent timers behind a 16-bit register bus; optional counter
// snapshot via MULTI_TIMER_SNAPSHOT_EN (rev 1.0)
`default_nettype none

module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int          NUM_CH     = 2,
  parameter int          CNT_W      = 32,
  parameter logic [31:0] RST_PERIOD = 32'h02FAF07F
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [2+$clog2(NUM_CH):0]    address,
  input  logic                         chipselect,
  input  logic                         write_n,
  input  logic [15:0]                  writedata,
  output logic [15:0]                  readdata,
  output logic                         irq,
  output logic [NUM_CH-1:0]            timeout_pulse
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [2:0]        ch_sel;
  ch_view_t          views [NUM_CH];
  logic [NUM_CH-1:0] ch_irq;
  ch_view_t          rd_view;
  logic [15:0]       readdata_d, readdata_q;

  generate
    if (CH_W == 0) begin : g_sel_single
      assign ch_sel = 3'd0;
    end else begin : g_sel_multi
      assign ch_sel = 3'(address[2+CH_W:3]);
    end
  endgenerate

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    multi_timer_ch #(
      .CNT_W      (CNT_W),
      .RST_PERIOD (RST_PERIOD)
    ) u_ch (
      .clk             (clk),
      .reset_n         (reset_n),
      .wr_en_i         (chipselect && !write_n && (ch_sel == 3'(ch))),
      .wr_addr_i       (address[2:0]),
      .wr_data_i       (writedata),
      .view_o          (views[ch]),
      .timeout_pulse_o (timeout_pulse[ch]),
      .irq_o           (ch_irq[ch])
    );
  end

  // Reads ignore chipselect; an unpopulated channel index reads as all zeros.
  always_comb begin
    rd_view = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 3'(i)) rd_view = views[i];
    end
    readdata_d = '0;
    case (address[2:0])
      REG_STATUS:  readdata_d = 16'({rd_view.run, rd_view.to_flag});
      REG_CONTROL: readdata_d = 16'({rd_view.cont, rd_view.ito});
      REG_PERIODL: readdata_d = rd_view.period[15:0];
      REG_PERIODH: readdata_d = rd_view.period[31:16];
      REG_SNAPL:   readdata_d = rd_view.snap[15:0];
      REG_SNAPH:   readdata_d = rd_view.snap[31:16];
      default:     readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;
  assign irq      = |ch_irq;

endmodule

`default_nettype wire

// File: tb/tb_multi_timer.sv
// tb_multi_timer -- directed and random register traffic against a cycle-level timer model (rev 1.0)
`default_nettype none

module tb_multi_timer;

  localparam logic [31:0] RST_P = 32'h02FAF07F;

  logic        clk;
  logic        reset_n;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;
  logic [1:0]  timeout_pulse;

  int checks = 0;
  int errors = 0;
  int pcnt0, pcnt1;

  // Model state: time left before timeout, configuration, flags.
  int unsigned m_period [2];
  int unsigned m_count  [2];
  int unsigned m_snap   [2];
  bit          m_run [2], m_to [2], m_cont [2], m_ito [2], m_reload [2];
  logic [1:0]  m_pulse;
  bit          m_irq;

  multi_timer #(
    .NUM_CH     (2),
    .CNT_W      (32),
    .RST_PERIOD (RST_P)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .chipselect    (chipselect),
    .write_n       (write_n),
    .writedata     (writedata),
    .readdata      (readdata),
    .irq           (irq),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_period[c] = RST_P; m_count[c] = RST_P; m_snap[c] = 0;
      m_run[c] = 0; m_to[c] = 0; m_cont[c] = 0; m_ito[c] = 0; m_reload[c] = 0;
    end
    m_pulse = '0;
    m_irq   = 0;
  endtask

  function automatic logic [15:0] model_read(input logic [3:0] a);
    int c;
    c = int'(a[3]);
    case (a[2:0])
      3'd0:    return 16'({m_run[c], m_to[c]});
      3'd1:    return 16'({m_cont[c], m_ito[c]});
      3'd2:    return m_period[c][15:0];
      3'd3:    return m_period[c][31:16];
`ifdef MULTI_TIMER_SNAPSHOT_EN
      3'd4:    return m_snap[c][15:0];
      3'd5:    return m_snap[c][31:16];
`endif
      default: return 16'h0;
    endcase
  endfunction

  // Advance the model by one clock using the bus values currently driven.
  task automatic model_step();
    bit          wr, tmo;
    int          r;
    int unsigned old_count;
    m_irq = 0;
    for (int c = 0; c < 2; c++) begin
      wr        = chipselect && !write_n && (int'(address[3]) == c);
      r         = int'(address[2:0]);
      old_count = m_count[c];
      tmo       = m_run[c] && (m_count[c] == 0);
      m_pulse[c] = tmo;
      if (m_reload[c] || tmo) m_count[c] = m_period[c];
      else if (m_run[c])      m_count[c] = m_count[c] - 1;
      m_reload[c] = 0;
      if (tmo) begin
        m_to[c]  = 1;
        m_run[c] = m_cont[c];
      end else if (wr && r == 0) begin
        m_to[c] = 0;
      end
      if (wr && r == 1) begin
        m_cont[c] = writedata[1];
        m_ito[c]  = writedata[0];
        if (writedata[3])      m_run[c] = 0;
        else if (writedata[2]) m_run[c] = 1;
      end
      if (wr && (r == 2 || r == 3)) begin
        if (r == 2) m_period[c] = (m_period[c] & 32'hFFFF0000) | 32'(writedata);
        else        m_period[c] = (m_period[c] & 32'h0000FFFF) | (32'(writedata) << 16);
        m_run[c]    = 0;
        m_reload[c] = 1;
      end
`ifdef MULTI_TIMER_SNAPSHOT_EN
      if (wr && r == 4) m_snap[c] = old_count;
`endif
      if (m_to[c] && m_ito[c]) m_irq = 1;
    end
  endtask

  task automatic tick();
    logic [15:0] exp_rd;
    exp_rd = model_read(address);
    model_step();
    @(posedge clk);
    #1;
    chk("readdata", 32'(readdata), 32'(exp_rd));
    chk("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("count0", dut.g_ch[0].u_ch.count_q, m_count[0]);
    chk("count1", dut.g_ch[1].u_ch.count_q, m_count[1]);
    pcnt0 += int'(timeout_pulse[0]);
    pcnt1 += int'(timeout_pulse[1]);
  endtask

  task automatic wr(input int ch, input int r, input int d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 4'(ch * 8 + r);
    writedata  = 16'(d);
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input int ch, input int r);
    address = 4'(ch * 8 + r);
    tick();
  endtask

  initial begin
    bit found;
    clk = 1'b0; reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = '0; writedata = '0;
    pcnt0 = 0; pcnt1 = 0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readdata", 32'(readdata), 32'h0);
    chk("rst_pulse", 32'(timeout_pulse), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_count", dut.g_ch[0].u_ch.count_q, RST_P);
    reset_n = 1'b1;
    rd(0, 2); chk("rst_periodl", 32'(readdata), 32'hF07F);
    rd(0, 3); chk("rst_periodh", 32'(readdata), 32'h02FA);
    rd(0, 1); chk("rst_control", 32'(readdata), 32'h0);
    rd(1, 0); chk("rst_status1", 32'(readdata), 32'h0);

    // Continuous mode, period 4: one pulse every 5 cycles
    wr(0, 2, 4); wr(0, 3, 0); wr(0, 1, 6);
    repeat (3) tick();
    pcnt0 = 0;
    repeat (15) tick();
    chk("cont_pulses", 32'(pcnt0), 32'd3);
    rd(0, 0); chk("cont_status", 32'(readdata), 32'h3);

    // One-shot: a single pulse, then stopped with counter reloaded
    wr(0, 1, 8); wr(0, 0, 0); wr(0, 1, 4);
    pcnt0 = 0;
    repeat (15) tick();
    chk("oneshot_pulses", 32'(pcnt0), 32'd1);
    rd(0, 0); chk("oneshot_status", 32'(readdata), 32'h1);
    chk("oneshot_count", dut.g_ch[0].u_ch.count_q, 32'd4);

    // Interrupt raise, clear, and set-wins-over-clear
    wr(0, 0, 0); wr(0, 1, 7);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (irq) found = 1;
    end
    chk("irq_rise_bound", 32'(found), 32'h1);
    wr(0, 0, 0); chk("irq_cleared", 32'(irq), 32'h0);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (m_run[0] && m_count[0] == 0) begin
        wr(0, 0, 0);
        found = 1;
      end else begin
        tick();
      end
    end
    chk("to_clear_collide_bound", 32'(found), 32'h1);
    chk("to_set_wins_irq", 32'(irq), 32'h1);
    rd(0, 0); chk("to_set_wins_status", 32'(readdata), 32'h3);

    // STOP beats START; other channel keeps running
    wr(1, 2, 9); wr(1, 3, 0); wr(1, 1, 6);
    repeat (2) tick();
    wr(0, 1, 12);
    rd(0, 0); chk("stop_wins_run", 32'(readdata[1]), 32'h0);
    rd(1, 0); chk("ch1_still_run", 32'(readdata[1]), 32'h1);

    // Period write while running stops the channel and reloads next cycle
    wr(0, 1, 6);
    repeat (3) tick();
    wr(0, 3, 1); wr(0, 2, 0);
    tick();
    chk("period_reload", dut.g_ch[0].u_ch.count_q, 32'h0001_0000);
    rd(0, 0); chk("period_wr_run", 32'(readdata[1]), 32'h0);

`ifdef MULTI_TIMER_SNAPSHOT_EN
    wr(0, 3, 0); wr(0, 2, 100); wr(0, 1, 4);
    repeat (10) tick();
    wr(0, 4, 0);
    rd(0, 4); chk("snapl", 32'(readdata), 32'd90);
    rd(0, 5); chk("snaph", 32'(readdata), 32'd0);
`else
    wr(0, 4, 16'h1234);
    rd(0, 4); chk("snapl_absent", 32'(readdata), 32'h0);
    rd(0, 5); chk("snaph_absent", 32'(readdata), 32'h0);
`endif

    // Random traffic against the model
    repeat (400) begin
      int op;
      op      = int'($urandom_range(0, 9));
      address = 4'($urandom_range(0, 15));
      if (op < 4) begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        case (address[2:0])
          3'd2:    writedata = 16'($urandom_range(0, 10));
          3'd3:    writedata = ($urandom_range(0, 7) == 0) ? 16'h1 : 16'h0;
          default: writedata = 16'($urandom);
        endcase
      end else begin
        chipselect = 1'b0;
        write_n    = 1'($urandom_range(0, 1));
        writedata  = 16'($urandom);
      end
      tick();
    end
    chipselect = 1'b0; write_n = 1'b1;

    // Reset in the middle of counting
    wr(0, 3, 0); wr(0, 2, 2); wr(0, 1, 7);
    wr(1, 3, 0); wr(1, 2, 3); wr(1, 1, 7);
    repeat (6) tick();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_pulse", 32'(timeout_pulse), 32'h0);
    chk("midrst_irq", 32'(irq), 32'h0);
    chk("midrst_readdata", 32'(readdata), 32'h0);
    chk("midrst_count", dut.g_ch[0].u_ch.count_q, RST_P);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    address = '0;
    pcnt0 = 0; pcnt1 = 0;
    repeat (20) tick();
    chk("no_pulse_after_reset", 32'(pcnt0 + pcnt1), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
